// File: rtl/uart_pkg.sv
// Shared definitions for the FIFO-backed UART transmitter: FSM encoding,
// frame-format constants and the data-bit-count decode.
package uart_pkg;

    localparam int unsigned UART_DATA_W_DEF     = 8;
    localparam int unsigned UART_FIFO_DEPTH_DEF = 16;

    // Legacy numeric state codes kept so older tooling and dumps still line up
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE   = ST_IDLE,
        S_START  = ST_START,
        S_DATA   = ST_DATA,
        S_PARITY = ST_PARITY,
        S_STOP   = ST_STOP
    } tx_state_e;

    localparam logic [1:0] BITS_5 = 2'd0;
    localparam logic [1:0] BITS_6 = 2'd1;
    localparam logic [1:0] BITS_7 = 2'd2;
    localparam logic [1:0] BITS_8 = 2'd3;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    // Encoded width 0..3 means 5..8 bits, never more than the datapath holds
    function automatic int unsigned data_bits_cnt(input logic [1:0] enc,
                                                  input int unsigned max_bits);
        int unsigned n;
        n = 32'd5 + {30'd0, enc};
        return (n > max_bits) ? max_bits : n;
    endfunction

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Host-side write port of the transmitter: byte strobe in, FIFO status out.
interface uart_tx_fifo_if
    import uart_pkg::*;
#(
    parameter int unsigned DATA_W = UART_DATA_W_DEF,
    parameter int unsigned LVL_W  = $clog2(UART_FIFO_DEPTH_DEF) + 1
);

    logic              i_we_h;
    logic [DATA_W-1:0] i_tx_data;
    logic              o_full_h;
    logic              o_empty_h;
    logic [LVL_W-1:0]  o_level;
    logic              o_ovf_h;

    modport master (
        output i_we_h,
        output i_tx_data,
        input  o_full_h,
        input  o_empty_h,
        input  o_level,
        input  o_ovf_h
    );

    modport slave (
        input  i_we_h,
        input  i_tx_data,
        output o_full_h,
        output o_empty_h,
        output o_level,
        output o_ovf_h
    );

endinterface

// File: rtl/uart_fifo_sync.sv
// Single-clock FIFO with occupancy count; a push into a full FIFO is kept
// when a pop happens in the same cycle, otherwise it is dropped and flagged.
module uart_fifo_sync
    import uart_pkg::*;
#(
    parameter int unsigned DATA_W = UART_DATA_W_DEF,
    parameter int unsigned DEPTH  = UART_FIFO_DEPTH_DEF,
    parameter int unsigned LVL_W  = $clog2(DEPTH) + 1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_push_h,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_pop_h,
    output logic [DATA_W-1:0] o_data,
    output logic              o_full_h,
    output logic              o_empty_h,
    output logic [LVL_W-1:0]  o_level,
    output logic              o_ovf_h
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic              ovf_q, ovf_d;
    logic              full, empty, do_push, do_pop;

    assign full    = (level_q == LVL_W'(DEPTH));
    assign empty   = (level_q == '0);
    assign do_pop  = i_pop_h && !empty;
    assign do_push = i_push_h && (!full || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        ovf_d    = i_push_h && !do_push;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage needs no reset: the pointers alone define what is valid
    always_ff @(posedge i_clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= i_data;
        end
    end

    assign o_data    = mem_q[rd_ptr_q];
    assign o_full_h  = full;
    assign o_empty_h = empty;
    assign o_level   = level_q;
    assign o_ovf_h   = ovf_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// RS-232 transmitter with run-time frame format (5..8 data bits, parity,
// 1/2 stop bits), oversampled baud timing and a write-side TX FIFO.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned OVS        = 4,
    parameter int unsigned DIV_W      = 16,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en_h,
    input  logic [DIV_W-1:0] i_div,
    input  logic [1:0]       i_data_bits,
    input  logic             i_stop2_h,
    input  logic             i_parity_en_h,
    input  logic             i_parity_type_el_oh,
    uart_tx_fifo_if.slave    bus,
    output logic             o_tx,
    output logic             o_busy_h,
    output logic             o_int_h
);

    localparam int unsigned OVS_W = $clog2(OVS);
    localparam int unsigned CNT_W = $clog2(DATA_W + 1);

    tx_state_e         state_q, state_d;
    logic [DIV_W-1:0]  cnt_q, cnt_d;
    logic [OVS_W-1:0]  ovs_q, ovs_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [CNT_W-1:0]  nbits_q, nbits_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic              stop2_q, stop2_d;
    logic              par_en_q, par_en_d;
    logic              par_q, par_d;
    logic              stop_cnt_q, stop_cnt_d;
    logic [DATA_W-1:0] sh_q, sh_d;
    logic              tx_q, tx_d;

    logic              fifo_pop;
    logic [DATA_W-1:0] fifo_rdata;
    logic              fifo_full, fifo_empty;
    logic              launch_ok, relaunch, tick, bit_end, int_h;
    int unsigned       n_launch;
    logic [DATA_W-1:0] act_mask;
    logic              par_calc;

    uart_fifo_sync #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH),
        .LVL_W  (LVL_W)
    ) u_fifo (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_push_h  (bus.i_we_h),
        .i_data    (bus.i_tx_data),
        .i_pop_h   (fifo_pop),
        .o_data    (fifo_rdata),
        .o_full_h  (fifo_full),
        .o_empty_h (fifo_empty),
        .o_level   (bus.o_level),
        .o_ovf_h   (bus.o_ovf_h)
    );

    assign bus.o_full_h  = fifo_full;
    assign bus.o_empty_h = fifo_empty;

    assign launch_ok = i_en_h && (i_div != '0) && !fifo_empty;
    assign tick      = (state_q != S_IDLE) && (cnt_q == div_q);
    assign bit_end   = tick && (ovs_q == OVS_W'(OVS - 1));

    // Parity covers only the data bits that will actually be sent
    always_comb begin
        n_launch = data_bits_cnt(i_data_bits, DATA_W);
        act_mask = '0;
        for (int unsigned i = 0; i < DATA_W; i++) begin
            act_mask[i] = (i < n_launch);
        end
        par_calc = (^(fifo_rdata & act_mask)) ^ (i_parity_type_el_oh == PAR_ODD);
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ovs_d      = ovs_q;
        div_d      = div_q;
        nbits_d    = nbits_q;
        bit_cnt_d  = bit_cnt_q;
        stop2_d    = stop2_q;
        par_en_d   = par_en_q;
        par_d      = par_q;
        stop_cnt_d = stop_cnt_q;
        sh_d       = sh_q;
        tx_d       = tx_q;
        int_h      = 1'b0;
        fifo_pop   = 1'b0;
        relaunch   = 1'b0;

        if (state_q != S_IDLE) begin
            if (tick) begin
                cnt_d = '0;
                ovs_d = bit_end ? '0 : ovs_q + OVS_W'(1);
            end else begin
                cnt_d = cnt_q + DIV_W'(1);
            end
        end

        // tx_q always holds the level of the bit currently on the line, so
        // each bit boundary loads the value of the bit that follows it
        case (state_q)
            S_IDLE: begin
                relaunch = launch_ok;
            end
            S_START: begin
                if (bit_end) begin
                    state_d   = S_DATA;
                    bit_cnt_d = '0;
                    tx_d      = sh_q[0];
                    sh_d      = sh_q >> 1;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    if (bit_cnt_q == nbits_q - CNT_W'(1)) begin
                        if (par_en_q) begin
                            state_d = S_PARITY;
                            tx_d    = par_q;
                        end else begin
                            state_d    = S_STOP;
                            tx_d       = 1'b1;
                            stop_cnt_d = 1'b0;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        tx_d      = sh_q[0];
                        sh_d      = sh_q >> 1;
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    state_d    = S_STOP;
                    tx_d       = 1'b1;
                    stop_cnt_d = 1'b0;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    if (stop2_q && !stop_cnt_q) begin
                        stop_cnt_d = 1'b1;
                    end else begin
                        int_h    = 1'b1;
                        state_d  = S_IDLE;
                        tx_d     = 1'b1;
                        relaunch = launch_ok;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
            end
        endcase

        if (relaunch) begin
            fifo_pop = 1'b1;
            state_d  = S_START;
            tx_d     = 1'b0;
            cnt_d    = '0;
            ovs_d    = '0;
            div_d    = i_div;
            nbits_d  = CNT_W'(n_launch);
            stop2_d  = i_stop2_h;
            par_en_d = i_parity_en_h;
            par_d    = par_calc;
            sh_d     = fifo_rdata;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            ovs_q      <= '0;
            div_q      <= '0;
            nbits_q    <= '0;
            bit_cnt_q  <= '0;
            stop2_q    <= 1'b0;
            par_en_q   <= 1'b0;
            par_q      <= 1'b0;
            stop_cnt_q <= 1'b0;
            sh_q       <= '0;
            tx_q       <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ovs_q      <= ovs_d;
            div_q      <= div_d;
            nbits_q    <= nbits_d;
            bit_cnt_q  <= bit_cnt_d;
            stop2_q    <= stop2_d;
            par_en_q   <= par_en_d;
            par_q      <= par_d;
            stop_cnt_q <= stop_cnt_d;
            sh_q       <= sh_d;
            tx_q       <= tx_d;
        end
    end

    assign o_tx     = tx_q;
    assign o_int_h  = int_h;
    assign o_busy_h = !fifo_empty || (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench: stimulus queues hand-derived line patterns, a monitor
// decodes every frame on o_tx and checks bits, o_int_h timing and gaps.
module tb_uart_tx_fifo;

    localparam int BCLK = 8;

    typedef struct {
        logic [15:0] bits;
        int          n;
        int          lat_ref;
        bit          b2b;
        bit          chk_busy;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [15:0] div;
    logic [1:0] data_bits;
    logic       stop2;
    logic       par_en;
    logic       par_type;
    logic       o_tx, o_busy_h, o_int_h;

    int   total, bad;
    int   cyc, int_cnt, ovf_cnt, frames_done;
    bit   mon_busy;
    exp_t sb_q[$];

    uart_tx_fifo_if #(.DATA_W(8), .LVL_W(5)) bus ();

    uart_tx_fifo #(
        .DATA_W     (8),
        .OVS        (4),
        .DIV_W      (16),
        .FIFO_DEPTH (16),
        .LVL_W      (5)
    ) dut (
        .i_clk               (clk),
        .i_rst_n             (rst_n),
        .i_en_h              (en),
        .i_div               (div),
        .i_data_bits         (data_bits),
        .i_stop2_h           (stop2),
        .i_parity_en_h       (par_en),
        .i_parity_type_el_oh (par_type),
        .bus                 (bus),
        .o_tx                (o_tx),
        .o_busy_h            (o_busy_h),
        .o_int_h             (o_int_h)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (o_int_h === 1'b1) int_cnt <= int_cnt + 1;
        if (bus.o_ovf_h === 1'b1) ovf_cnt <= ovf_cnt + 1;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    function automatic void expect_frame(input logic [15:0] bits, input int n,
                                         input int lat_ref, input bit b2b, input bit chk_busy);
        exp_t e;
        e.bits = bits; e.n = n; e.lat_ref = lat_ref; e.b2b = b2b; e.chk_busy = chk_busy;
        sb_q.push_back(e);
    endfunction

    task automatic wr(input logic [7:0] d);
        bus.i_we_h    = 1'b1;
        bus.i_tx_data = d;
        @(negedge clk);
        bus.i_we_h    = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int k;
        k = 0;
        while ((sb_q.size() != 0 || mon_busy) && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (k >= budget) begin
            total++; bad++;
            $display("FAIL idle_timeout pending=%0d required=0", sb_q.size());
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_start(input int budget);
        int k;
        for (k = 0; k < budget; k++) begin
            if (o_tx === 1'b0) break;
            @(negedge clk);
        end
        if (k >= budget) begin
            total++; bad++;
            $display("FAIL start_timeout o_tx=%b required=0", o_tx);
        end
    endtask

    // Monitor: one scoreboard entry per falling start edge
    exp_t        it;
    logic [15:0] got;
    bit          stable, int_ok, aborted;
    int          start_c, last_end;

    initial begin : monitor
        mon_busy = 1'b0;
        last_end = -10;
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1 || o_tx !== 1'b0) continue;
            if (sb_q.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_frame at_cycle=%0d required=none", cyc);
                for (int k = 0; k < 200 && o_tx !== 1'b1; k++) @(negedge clk);
                continue;
            end
            it = sb_q.pop_front();
            mon_busy = 1'b1;
            start_c = cyc;
            got = '0; stable = 1'b1; int_ok = 1'b1; aborted = 1'b0;
            for (int b = 0; b < it.n; b++) begin
                if (aborted) break;
                for (int c = 0; c < BCLK; c++) begin
                    if (b != 0 || c != 0) @(negedge clk);
                    if (rst_n !== 1'b1) begin aborted = 1'b1; break; end
                    if (c == 0) got[b] = o_tx;
                    else if (o_tx !== got[b]) stable = 1'b0;
                    if (o_int_h !== ((b == it.n - 1) && (c == BCLK - 1))) int_ok = 1'b0;
                end
            end
            if (!aborted) begin
                total++;
                if (!stable || got !== it.bits) begin
                    bad++;
                    $display("FAIL frame got=%0h exp=%0h stable=%0b", got, it.bits, stable);
                end
                chk("int_timing", 32'(int_ok), 32'd1);
                if (it.lat_ref >= 0) chk("launch_latency", 32'(start_c - it.lat_ref), 32'd2);
                if (it.b2b) chk("b2b_gap", 32'(start_c - last_end), 32'd1);
                last_end = cyc;
                frames_done++;
                if (it.chk_busy) begin
                    @(negedge clk);
                    chk("busy_drop", 32'(o_busy_h), 32'd0);
                end
            end
            mon_busy = 1'b0;
        end
    end

    int int0, ovf0;

    initial begin : stim
        total = 0; bad = 0; cyc = 0; int_cnt = 0; ovf_cnt = 0; frames_done = 0;
        rst_n = 1'b1; en = 1'b0; div = 16'd1; data_bits = 2'd3;
        stop2 = 1'b0; par_en = 1'b0; par_type = 1'b0;
        bus.i_we_h = 1'b0; bus.i_tx_data = '0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_tx", 32'(o_tx), 32'd1);
        chk("rst_busy", 32'(o_busy_h), 32'd0);
        chk("rst_full", 32'(bus.o_full_h), 32'd0);
        chk("rst_empty", 32'(bus.o_empty_h), 32'd1);
        chk("rst_level", 32'(bus.o_level), 32'd0);
        chk("rst_int", 32'(o_int_h), 32'd0);
        chk("rst_ovf", 32'(bus.o_ovf_h), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // 8N1 0x55: 0,1,0,1,0,1,0,1,0,1
        en = 1'b1;
        expect_frame(16'h02AA, 10, cyc, 1'b0, 1'b1);
        wr(8'h55);
        wait_idle(300);

        // 8E1 0xA1: three ones -> parity 1
        par_en = 1'b1; par_type = 1'b0;
        expect_frame(16'h0742, 11, -1, 1'b0, 1'b1);
        wr(8'hA1);
        wait_idle(300);

        // 7O2 0x7F: seven ones -> parity 0; config scrambled mid-frame
        data_bits = 2'd2; stop2 = 1'b1; par_type = 1'b1;
        expect_frame(16'h06FE, 11, -1, 1'b0, 1'b1);
        wr(8'h7F);
        wait_start(20);
        data_bits = 2'd3; stop2 = 1'b0; par_en = 1'b0; div = 16'd3;
        wait_idle(300);
        div = 16'd1;

        // 5N1 0xFF: 7-bit frame
        data_bits = 2'd0;
        expect_frame(16'h007E, 7, -1, 1'b0, 1'b1);
        wr(8'hFF);
        wait_idle(300);
        data_bits = 2'd3;

        // Fill to full with transmitter disabled, 17th write dropped
        en = 1'b0;
        ovf0 = ovf_cnt;
        for (int i = 0; i < 16; i++) wr(8'(i));
        chk("fill_full", 32'(bus.o_full_h), 32'd1);
        chk("fill_level", 32'(bus.o_level), 32'd16);
        wr(8'h10);
        repeat (3) @(negedge clk);
        chk("ovf_pulse", 32'(ovf_cnt - ovf0), 32'd1);
        chk("ovf_level", 32'(bus.o_level), 32'd16);
        for (int i = 0; i < 16; i++)
            expect_frame(16'h0200 | (16'(i) << 1), 10, -1, (i != 0), 1'b0);
        en = 1'b1;
        wait_idle(16 * 80 + 200);
        chk("drain_empty", 32'(bus.o_empty_h), 32'd1);
        chk("drain_level", 32'(bus.o_level), 32'd0);
        chk("drain_busy", 32'(o_busy_h), 32'd0);

        // Full FIFO: write lands in the same cycle as the launch pop
        en = 1'b0;
        for (int i = 0; i < 16; i++) wr(8'h20 + 8'(i));
        chk("refill_full", 32'(bus.o_full_h), 32'd1);
        ovf0 = ovf_cnt;
        for (int i = 0; i < 16; i++)
            expect_frame(16'h0200 | (16'(8'h20 + 8'(i)) << 1), 10, -1, (i != 0), 1'b0);
        expect_frame(16'h0260, 10, -1, 1'b1, 1'b0);
        en = 1'b1;
        wr(8'h30);
        chk("simul_level", 32'(bus.o_level), 32'd16);
        repeat (2) @(negedge clk);
        chk("simul_no_ovf", 32'(ovf_cnt - ovf0), 32'd0);
        wait_idle(17 * 80 + 200);
        chk("simul_empty", 32'(bus.o_empty_h), 32'd1);

        // Disable mid-frame: frame completes, next byte held
        expect_frame(16'h0224, 10, -1, 1'b0, 1'b0);
        wr(8'h12);
        wr(8'h34);
        wait_start(20);
        repeat (20) @(negedge clk);
        en = 1'b0;
        wait_idle(300);
        repeat (50) @(negedge clk);
        chk("hold_level", 32'(bus.o_level), 32'd1);
        chk("hold_tx", 32'(o_tx), 32'd1);
        chk("hold_busy", 32'(o_busy_h), 32'd1);
        expect_frame(16'h0268, 10, -1, 1'b0, 1'b1);
        en = 1'b1;
        wait_idle(300);
        chk("resume_empty", 32'(bus.o_empty_h), 32'd1);

        // Reset during the fourth bit of a frame with another byte queued
        int0 = int_cnt;
        expect_frame(16'h02AA, 10, -1, 1'b0, 1'b0);
        wr(8'h55);
        wr(8'h33);
        wait_start(20);
        repeat (28) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_tx", 32'(o_tx), 32'd1);
        chk("midrst_level", 32'(bus.o_level), 32'd0);
        chk("midrst_busy", 32'(o_busy_h), 32'd0);
        chk("midrst_int", 32'(o_int_h), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        sb_q.delete();
        repeat (100) @(negedge clk);
        chk("midrst_no_int", 32'(int_cnt - int0), 32'd0);
        chk("midrst_idle_tx", 32'(o_tx), 32'd1);
        chk("midrst_empty", 32'(bus.o_empty_h), 32'd1);
        chk("int_count", 32'(int_cnt), 32'(frames_done));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Parametrised RS-232 transmitter with a built-in TX FIFO. It is the successor to the fixed 8-bit, 4x-oversampled transmitter. Adds run-time selectable 5..8 data bits, 1 or 2 stop bits, even/odd/no parity, a compile-time oversample factor, and a write-side FIFO so the host can queue bytes while a frame is in flight. It sits between the system bus register block and the o_tx pin.

Parameters:
DATA_W, 8, maximum data bits per frame; i_tx_data width.
OVS, 4, baud ticks per bit (>=2).
DIV_W, 16, width of the baud divider.
FIFO_DEPTH, 16, TX FIFO entries (power of 2, >=2).
LVL_W, $clog2(FIFO_DEPTH)+1, width of the level output.

Ports:
i_clk  in  1  system clock
i_rst_n  in  1  asynchronous active-low reset
i_en_h  in  1  transmitter enable
i_div  in  DIV_W  baud tick period minus 1; 0 = no frame launches
i_data_bits  in  2  data bits: 0=5, 1=6, 2=7, 3=8 (values above DATA_W are clamped to DATA_W)
i_stop2_h  in  1  0 = 1 stop bit, 1 = 2 stop bits
i_parity_en_h  in  1  parity bit enable
i_parity_type_el_oh  in  1  0 = even, 1 = odd
i_we_h  in  1  FIFO write strobe, one byte per cycle
i_tx_data  in  DATA_W  byte to queue; bit 0 is sent first
o_tx  out  1  serial line, idle high
o_busy_h  out  1  FIFO non-empty or frame active
o_full_h  out  1  FIFO full
o_empty_h  out  1  FIFO empty
o_level  out  LVL_W  FIFO occupancy
o_int_h  out  1  1-cycle pulse at end of each frame's last stop bit
o_ovf_h  out  1  1-cycle pulse when a write is dropped

Behaviour:
- Reset values (async, take effect immediately): o_tx=1, o_busy_h=0, o_full_h=0, o_empty_h=1, o_level=0, o_int_h=0, o_ovf_h=0. FIFO is emptied and the FSM returns to IDLE. A reset mid-frame truncates the frame; the line returns high at once.
- FIFO writes:
  - A write is accepted when not full, or when full and the FSM pops in the same cycle; in that case the level is unchanged.
  - Otherwise the write is dropped and o_ovf_h pulses the next cycle.
  - Pop happens only on a non-empty FIFO. There is no fall-through.
- Baud generation:
  - The tick counter runs only while a frame is active and is cleared on frame launch.
  - A tick fires every i_div+1 clocks.
  - One bit lasts exactly OVS*(i_div+1) clocks.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - A frame launches when i_en_h=1, i_div!=0 and the FIFO is non-empty.
  - On launch: pop, latch the data word and all config inputs (i_div, bits, stop, parity), and drive o_tx=0.
  - Latency from a write into an empty FIFO to o_tx falling is 2 clocks.
- START: lasts one bit, then goes to DATA.
- DATA: sends the latched number of bits, LSB first; a bit counter selects the bit. Then goes to PARITY if enabled, else STOP.
- PARITY: one bit. Even makes the count of ones over data+parity even; odd makes it odd. Only active data bits are counted.
- STOP:
  - o_tx=1 for one or two bits.
  - At the last clock of the last stop bit, o_int_h pulses.
  - The FSM goes to IDLE, or relaunches in the same cycle if the launch condition holds. Back-to-back frames have no idle gap.
- Config and i_div changes mid-frame have no effect until the next launch.
- i_en_h falling mid-frame lets the current frame complete; no new frame launches. Queued data is retained.
- o_busy_h is combinational: (!o_empty_h) or (FSM != IDLE).

Decomposition:
- Package uart_pkg: FSM state enum, data-bits encoding constants, parity type constants (PAR_EVEN=0, PAR_ODD=1), a function mapping the encoded bit count to a count.
- One sub-module: uart_fifo_sync, a synchronous FIFO (DATA_W x FIFO_DEPTH) with full/empty/level and the simultaneous push/pop-at-full rule. The FSM, baud counter and parity logic stay in uart_tx_fifo.

Test Plan:
- 8N1 frame: OVS=4, i_div=1 (8 clk/bit), write 0x55 → o_tx falls 2 clk after write; pattern 0,1,0,1,0,1,0,1,0,1, each 8 clk; o_int_h pulses at clk 80 after the start edge; o_busy_h drops the following cycle.
- Parity and stop bits: 8E1 with 0xA1 → parity bit 1 (11 bits, 88 clk). 7O2 with 0x7F → 7 data bits, parity 0, stop high for 16 clk (11 bits total).
- 5-bit mode: i_data_bits=0, 8N1 otherwise, data 0xFF → only 5 data bits sent; frame is 7 bits = 56 clk.
- FIFO full/overflow: with i_en_h=0, write 17 bytes 0x00..0x10 → o_full_h=1 after the 16th, o_level=16, o_ovf_h pulses once. Then set i_en_h=1 → 16 frames back to back with no idle clocks; bytes 0x00..0x0F in order; o_empty_h=1 after the last pop.
- Simultaneous push at full: with the FIFO full, write in the exact cycle the FSM pops → write accepted, no o_ovf_h, o_level stays 16.
- Reset and disable mid-frame:
  - Assert i_rst_n=0 during bit 3 → o_tx=1 immediately, o_level=0, no o_int_h.
  - Separately, drop i_en_h mid-frame → the frame completes with o_int_h, and the next queued byte is held until re-enable.
